// File: rtl/turfio_cout_arbiter.sv
// turfio_cout_arbiter: shares the COUT command stream between trigger, control and housekeeping sources
module turfio_cout_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 ifclk_i,
    input  logic                 rst_i,
    input  logic                 train_i,
    input  logic [31:0]          s0_tdata,
    input  logic                 s0_tvalid,
    output logic                 s0_tready,
    input  logic [31:0]          s1_tdata,
    input  logic                 s1_tvalid,
    output logic                 s1_tready,
    input  logic [31:0]          s2_tdata,
    input  logic                 s2_tvalid,
    output logic                 s2_tready,
    output logic [31:0]          cout_tdata,
    output logic                 cout_tvalid,
    input  logic                 cout_tready,
    output logic [CNT_WIDTH-1:0] cnt0_o,
    output logic [CNT_WIDTH-1:0] cnt1_o,
    output logic [CNT_WIDTH-1:0] cnt2_o,
    output logic                 starve_force_o
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic                 out_valid_q, out_valid_d;
    logic [31:0]          out_data_q, out_data_d;
    logic [1:0]           out_src_q, out_src_d;
    logic                 rr_ptr_q, rr_ptr_d;
    logic [3:0]           starve_cnt_q, starve_cnt_d;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic                 xfer, load, low_any, s0_first, pick2, g0, g1, g2;

    // grant decision: triggers first unless a low source has waited STARVE_LIMIT grants
    always_comb begin
        xfer     = out_valid_q && !train_i && cout_tready;
        load     = !rst_i && !train_i && (!out_valid_q || xfer);
        low_any  = s1_tvalid || s2_tvalid;
        pick2    = s2_tvalid && (rr_ptr_q || !s1_tvalid);
        s0_first = s0_tvalid && (starve_cnt_q < LIMIT);
        g0       = load && s0_tvalid && (s0_first || !low_any);
        g1       = load && !s0_first && s1_tvalid && !pick2;
        g2       = load && !s0_first && pick2;
    end

    // next-state for the holding register, round-robin pointer, starvation and delivery counters
    always_comb begin
        out_valid_d  = g0 || g1 || g2 || (out_valid_q && !xfer);
        out_data_d   = g0 ? s0_tdata : g1 ? s1_tdata : g2 ? s2_tdata : out_data_q;
        out_src_d    = g0 ? 2'd0 : g1 ? 2'd1 : g2 ? 2'd2 : out_src_q;
        rr_ptr_d     = g1 ? 1'b1 : g2 ? 1'b0 : rr_ptr_q;
        starve_cnt_d = (!low_any || g1 || g2) ? 4'd0 :
                       (g0 && starve_cnt_q < LIMIT) ? starve_cnt_q + 4'd1 : starve_cnt_q;
        cnt0_d       = cnt0_q + CNT_WIDTH'(xfer && out_src_q == 2'd0);
        cnt1_d       = cnt1_q + CNT_WIDTH'(xfer && out_src_q == 2'd1);
        cnt2_d       = cnt2_q + CNT_WIDTH'(xfer && out_src_q == 2'd2);
    end

    // state registers; reset drops any held word
    always_ff @(posedge ifclk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            rr_ptr_q     <= 1'b0;
            starve_cnt_q <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            cnt2_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            cnt2_q       <= cnt2_d;
        end
    end

    assign s0_tready      = g0;
    assign s1_tready      = g1;
    assign s2_tready      = g2;
    assign cout_tvalid    = out_valid_q && !train_i;
    assign cout_tdata     = out_data_q;
    assign cnt0_o         = cnt0_q;
    assign cnt1_o         = cnt1_q;
    assign cnt2_o         = cnt2_q;
    assign starve_force_o = (g1 || g2) && s0_tvalid;
endmodule

// File: tb/tb_turfio_cout_arbiter.sv
// tb_turfio_cout_arbiter: table vectors, directed sequences and random traffic against a behavioural model
module tb_turfio_cout_arbiter;
    localparam int LIM = 4;
    localparam int CW  = 16;

    logic          ifclk = 1'b0;
    logic          rst, train, v0, v1, v2, r0, r1, r2, cv, crdy, sf;
    logic [31:0]   d0, d1, d2, ct;
    logic [CW-1:0] c0, c1, c2;

    always #5 ifclk = ~ifclk;

    turfio_cout_arbiter #(.STARVE_LIMIT(LIM), .CNT_WIDTH(CW)) dut (
        .ifclk_i(ifclk), .rst_i(rst), .train_i(train),
        .s0_tdata(d0), .s0_tvalid(v0), .s0_tready(r0),
        .s1_tdata(d1), .s1_tvalid(v1), .s1_tready(r1),
        .s2_tdata(d2), .s2_tvalid(v2), .s2_tready(r2),
        .cout_tdata(ct), .cout_tvalid(cv), .cout_tready(crdy),
        .cnt0_o(c0), .cnt1_o(c1), .cnt2_o(c2), .starve_force_o(sf)
    );

    int errors = 0;
    int checks = 0;
    int tick = 0;

    // behavioural model: held word, per-source delivery counts, low-source waiting streak, last low winner
    bit          m_valid;
    logic [31:0] m_data;
    int          m_src;
    int          m_cnt[3];
    int          m_starve;
    int          last_low;
    int          dq_src[$];
    logic [31:0] dq_data[$];
    logic [2:0]  obs_rdy;
    logic        obs_cv, obs_sf;

    typedef struct {
        bit       train;
        bit [2:0] v;
        bit       rdy;
        bit [2:0] er;
        bit       ecv;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_src = 0; m_cnt = '{0, 0, 0}; m_starve = 0; last_low = 0;
    endtask

    // one clock: drive at posedge+1, sample and compare mid-cycle, advance model at the next posedge
    task automatic cyc(input bit r, input bit t, input bit [2:0] v, input bit rdy);
        bit       xf, ld, fc;
        int       first, second, lw, win;
        bit [2:0] er;
        rst = r; train = t; {v2, v1, v0} = v; crdy = rdy;
        #3;
        xf     = m_valid && !t && rdy;
        ld     = !r && !t && (!m_valid || xf);
        first  = (last_low == 1) ? 2 : 1;
        second = 3 - first;
        lw     = v[first] ? first : v[second] ? second : -1;
        if (!ld) win = -1;
        else if (v[0] && m_starve < LIM) win = 0;
        else if (lw > 0) win = lw;
        else if (v[0]) win = 0;
        else win = -1;
        er = (win >= 0) ? 3'(1 << win) : 3'b000;
        fc = (win > 0) && v[0];
        obs_rdy = {r2, r1, r0}; obs_cv = cv; obs_sf = sf;
        chk("tvalid", cv, m_valid && !t);
        if (m_valid && !t) chk("tdata", ct, m_data);
        chk("tready", {r2, r1, r0}, er);
        chk("force", sf, fc);
        chk("cnt0", c0, CW'(m_cnt[0]));
        chk("cnt1", c1, CW'(m_cnt[1]));
        chk("cnt2", c2, CW'(m_cnt[2]));
        @(posedge ifclk);
        tick++;
        if (r) model_reset();
        else begin
            if (xf) begin
                m_cnt[m_src]++;
                dq_src.push_back(m_src);
                dq_data.push_back(m_data);
            end
            if (win >= 0) begin
                m_valid = 1; m_src = win;
                m_data = (win == 0) ? d0 : (win == 1) ? d1 : d2;
            end else if (xf) m_valid = 0;
            if (!v[1] && !v[2]) m_starve = 0;
            else if (win > 0) m_starve = 0;
            else if (win == 0 && m_starve < LIM) m_starve++;
            if (win > 0) last_low = win;
        end
        #1;
    endtask

    task automatic do_reset();
        cyc(1, 0, 3'b000, 0);
        cyc(1, 0, 3'b000, 0);
        dq_src.delete();
        dq_data.delete();
    endtask

    initial begin
        int  k, nforce, nlow, c1_start;
        bit  any_rdy, any_cv;
        int  exp_all[10];
        exp_all = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
        rst = 1; train = 0; v0 = 0; v1 = 0; v2 = 0; crdy = 0;
        d0 = 32'hA0A0A0A0; d1 = 32'h12345678; d2 = 32'hB2B2B2B2;
        model_reset();
        tbl[0]  = '{0, 3'b010, 0, 3'b010, 1'b0};
        tbl[1]  = '{0, 3'b000, 0, 3'b000, 1'b1};
        tbl[2]  = '{0, 3'b000, 1, 3'b000, 1'b1};
        tbl[3]  = '{0, 3'b000, 0, 3'b000, 1'b0};
        tbl[4]  = '{0, 3'b001, 0, 3'b001, 1'b0};
        tbl[5]  = '{1, 3'b010, 1, 3'b000, 1'b0};
        tbl[6]  = '{0, 3'b010, 0, 3'b000, 1'b1};
        tbl[7]  = '{0, 3'b010, 1, 3'b010, 1'b1};
        tbl[8]  = '{0, 3'b000, 0, 3'b000, 1'b1};
        tbl[9]  = '{0, 3'b000, 1, 3'b000, 1'b1};
        tbl[10] = '{0, 3'b000, 0, 3'b000, 1'b0};
        @(posedge ifclk);
        #1;
        do_reset();
        chk("rst_tvalid", cv, 0);
        chk("rst_cnt0", c0, 0);
        chk("rst_cnt1", c1, 0);
        chk("rst_cnt2", c2, 0);
        chk("rst_force", sf, 0);

        // table: single s1 word, then training while a word is held
        for (int i = 0; i < 11; i++) begin
            cyc(0, tbl[i].train, tbl[i].v, tbl[i].rdy);
            chk($sformatf("tbl%0d_rdy", i), obs_rdy, tbl[i].er);
            chk($sformatf("tbl%0d_cv", i), obs_cv, tbl[i].ecv);
            if (i == 3) begin
                chk("single_n", dq_src.size(), 1);
                if (dq_src.size() > 0) chk("single_data", dq_data[0], 32'h12345678);
                chk("single_cnt1", c1, 1);
            end
        end

        // all three sources valid, serializer slot every 8 cycles
        do_reset();
        nforce = 0; nlow = 0;
        for (int i = 0; i < 96; i++) begin
            d0 = $urandom; d1 = $urandom; d2 = $urandom;
            cyc(0, 0, 3'b111, (tick % 8) == 7);
            nforce += obs_sf;
            nlow += obs_rdy[1] + obs_rdy[2];
        end
        chk("all_n", dq_src.size() >= 10, 1);
        for (int i = 0; i < 10 && i < dq_src.size(); i++) chk($sformatf("all_src%0d", i), dq_src[i], exp_all[i]);
        chk("all_force_low", nforce, nlow);
        chk("all_force_n", nforce >= 2, 1);

        // s1 and s2 only: strict alternation starting with s1
        do_reset();
        for (int i = 0; i < 40; i++) cyc(0, 0, 3'b110, (tick % 8) == 7);
        chk("rr_n", dq_src.size() >= 4, 1);
        for (int i = 0; i < 4 && i < dq_src.size(); i++) chk($sformatf("rr_src%0d", i), dq_src[i], (i % 2) + 1);

        // word held through 20 training cycles spanning two tready pulses
        do_reset();
        d1 = 32'hCAFE0001;
        cyc(0, 0, 3'b010, 0);
        any_rdy = 0; any_cv = 0; c1_start = c1;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 3'b101, (tick % 8) == 7);
            any_rdy |= (obs_rdy != 0);
            any_cv |= obs_cv;
        end
        chk("train_rdy", any_rdy, 0);
        chk("train_cv", any_cv, 0);
        chk("train_cnt", c1, c1_start);
        k = 0;
        while (dq_src.size() == 0 && k < 16) begin
            cyc(0, 0, 3'b000, (tick % 8) == 7);
            k++;
        end
        chk("train_deliv", dq_src.size(), 1);
        if (dq_src.size() > 0) chk("train_data", dq_data[0], 32'hCAFE0001);
        chk("train_cnt1", c1, 1);

        // tready always high: s0 stream delivered one word per cycle with no gap
        do_reset();
        k = 0;
        for (int i = 0; i < 11; i++) begin
            d0 = k;
            cyc(0, 0, (k < 10) ? 3'b001 : 3'b000, 1);
            if (obs_rdy[0]) k++;
        end
        chk("stream_n", dq_data.size(), 10);
        for (int i = 0; i < dq_data.size(); i++) chk($sformatf("stream_d%0d", i), dq_data[i], i);

        // reset while a word is pending and counters are non-zero
        do_reset();
        d1 = 32'h55AA55AA;
        for (int i = 0; i < 6; i++) cyc(0, 0, 3'b010, 1);
        chk("pre_rst_cnt1", c1, 5);
        cyc(1, 0, 3'b000, 0);
        chk("mid_rst_cv", cv, 0);
        chk("mid_rst_cnt1", c1, 0);
        chk("mid_rst_cnt0", c0, 0);
        chk("mid_rst_force", sf, 0);
        dq_src.delete();
        for (int i = 0; i < 10; i++) cyc(0, 0, 3'b000, 1);
        chk("mid_rst_nodeliv", dq_src.size(), 0);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit t, r, rdy;
            d0 = $urandom; d1 = $urandom; d2 = $urandom;
            if ($urandom_range(19) == 0) train = ~train;
            t = train;
            r = ($urandom_range(199) == 0);
            rdy = (i < 1500) ? ((tick % 8) == 7) : $urandom_range(1);
            cyc(r, t, {$urandom_range(2) != 0, $urandom_range(2) != 0, $urandom_range(2) != 0}, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/turfio_cout_arbiter.md
# turfio_cout_arbiter

Shares the single 32-bit COUT command stream between three command sources: a trigger source, a register/control source and a housekeeping source. Output is an AXI4-stream master that feeds the COUT serializer. The serializer asserts `cout_tready` for one ifclk cycle out of every 8, so each accepted word is exactly one COUT command slot. The arbiter gives fixed priority to triggers, round-robins the other two sources, bounds starvation, and suppresses output during link training.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive source-0 grants allowed while source 1/2 is pending; range 1..15.
- `CNT_WIDTH`, default 16: width of per-source grant counters.

Ports:
- `ifclk_i` in 1: single clock for the whole block; everything is synchronous to it.
- `rst_i` in 1: reset, synchronous, active-high.
- `train_i` in 1: link training active, already in the ifclk domain.
- `s0_tdata` in 32, `s0_tvalid` in 1, `s0_tready` out 1: trigger source (highest priority).
- `s1_tdata` in 32, `s1_tvalid` in 1, `s1_tready` out 1: register/control source.
- `s2_tdata` in 32, `s2_tvalid` in 1, `s2_tready` out 1: housekeeping source.
- `cout_tdata` out 32, `cout_tvalid` out 1, `cout_tready` in 1: to the serializer.
- `cnt0_o`, `cnt1_o`, `cnt2_o` out CNT_WIDTH: words delivered per source.
- `starve_force_o` out 1: one-cycle pulse when a starvation-forced grant occurs.

## Operation
- One output holding register: `out_valid`, `out_data` and `out_src` (2 bits).
- `load` condition: `!train_i && (!out_valid || xfer)`, where `xfer = cout_tvalid && cout_tready`.
- `cout_tvalid = out_valid && !train_i`. During training the held word is neither presented nor lost. The serializer's tready pulses during training transfer nothing.
- Grant is evaluated combinationally when `load` is true. Exactly one `sN_tready` is high, and only when `load` is true and that source wins. Input transfer follows the standard rule `sN_tvalid && sN_tready`.
- Winner selection:
  - If `s0_tvalid` and `starve_cnt < STARVE_LIMIT`: grant source 0.
  - Otherwise grant the round-robin pick among valid sources 1/2, starting from `rr_ptr`.
  - Otherwise, if `s0_tvalid` (starve limit reached but no low request), grant source 0.
  - Otherwise, no grant.
- `rr_ptr` is 1 bit: 0 prefers s1, 1 prefers s2. It toggles to point away from the winner after each source-1/2 grant and is unchanged on source-0 grants.
- `starve_cnt` is 4 bits:
  - Increments on a source-0 grant while `s1_tvalid || s2_tvalid`.
  - Clears on any source-1/2 grant, or on any cycle with both `s1_tvalid` and `s2_tvalid` low.
  - Saturates at STARVE_LIMIT.
- `starve_force_o` pulses in the cycle where s0 is valid but a source-1/2 grant is issued because `starve_cnt == STARVE_LIMIT`.
- On a grant: `out_data <= sN_tdata`, `out_src <= N`, `out_valid <= 1`.
- On `xfer` with no grant: `out_valid <= 0`.
- `cntN_o` increments on `xfer` when `out_src == N`. Counters wrap modulo 2^CNT_WIDTH. They count serializer deliveries, not input acceptances.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_src=0`, `rr_ptr=0`, `starve_cnt=0`, all `cntN_o=0`, `starve_force_o=0`. All `sN_tready` are low in reset cycles.
- Input accept to `cout_tvalid` high: 1 cycle, when not training.
- Back-to-back: a new word is loaded in the same cycle as the `xfer`. Zero bubble, so every serializer slot can be filled.
- `cout_tdata` is stable while `cout_tvalid && !cout_tready`. `out_data` changes only on load.
- `train_i` rising while `out_valid`: word held; delivered at the first tready after `train_i` falls.
- `train_i` asserted on the same cycle as `cout_tready`: no transfer, no counter increment.
- Reset mid-operation: the held word is dropped, `out_valid` clears next cycle, counters clear.
- Simultaneous `xfer` and grant: both are honoured, and the counter for the outgoing `out_src` increments.

## Test plan
- Single s1 word `0x12345678`, tready pulsing every 8 cycles:
  - `s1_tready` high 1 cycle after reset release.
  - `cout_tvalid` high next cycle.
  - Delivered at the next tready.
  - `cnt1_o=1`.
- s0, s1 and s2 all continuously valid, STARVE_LIMIT=4: delivered source order 0,0,0,0,1,0,0,0,0,2,0,… `starve_force_o` pulses once per low grant.
- s1 and s2 only, both continuously valid: alternating order 1,2,1,2. Starting from reset, s1 goes first.
- Word loaded, then `train_i=1` for 20 cycles covering 2 tready pulses:
  - `cout_tvalid=0` and no counters change while training.
  - Word delivered at the first tready after `train_i` falls.
  - No other `sN_tready` high during training.
- `cout_tready` held high constantly, s0 streaming 0,1,2,…: one word transferred per cycle after the first, no gaps, data in order.
- `rst_i` pulsed with a word pending and counters at 5: all outputs return to zero next cycle, and the pending word is never delivered.
